// File: rtl/adc_gate_capture_if.sv
// Storage-side write handshake for adc_gate_capture.
// The capture block drives WRITE/DOUT (master); the storage FIFO drives
// READY2WRITE (slave).
interface adc_gate_capture_if;
  logic        READY2WRITE;
  logic        WRITE;
  logic [15:0] DOUT;

  modport master (
    input  READY2WRITE,
    output WRITE,
    output DOUT
  );

  modport slave (
    output READY2WRITE,
    input  WRITE,
    input  DOUT
  );
endinterface

// File: rtl/adc_gate_capture.sv
// adc_gate_capture: gated ADC sample capture with block averaging.
// While the gate window (DEMOD_ON) is open, ADC samples taken on RX_CLK
// rising edges are summed in blocks of 2^AVG_LOG2. Each complete block
// average goes to a one-deep pending register and is handed to storage
// through the write interface. When the gate closes, the partial block is
// dropped, the pending word is drained, and GATE_DONE pulses once.
// Optional build macro: OTR_CLAMP_EN -- clamp out-of-range samples to
// full scale (+8191 / -8192) before accumulation. When undefined, RX is
// used as-is and RX_OTR is ignored.
module adc_gate_capture #(
  parameter int AVG_LOG2 = 2,
  parameter int GATE_MAX = 64
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               ENABLE,
  input  logic               RX_CLK,
  input  logic [13:0]        RX,
  input  logic               RX_OTR,
  input  logic               DEMOD_ON,
  adc_gate_capture_if.master wr,
  output logic               GATE_DONE,
  output logic               OVERFLOW,
  output logic [7:0]         SAMPLE_CNT
);

  localparam int         DATA_W   = 14;
  localparam int         OUT_W    = 16;
  localparam int         ACC_W    = OUT_W + AVG_LOG2;
  localparam int         BLK_N    = 1 << AVG_LOG2;
  localparam logic [7:0] CNT_MAX  = 8'(GATE_MAX);
  localparam logic [4:0] BLK_LAST = 5'(BLK_N - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Block average: arithmetic shift of the block sum, truncated to output width.
  function automatic logic signed [OUT_W-1:0] f_avg(input logic signed [ACC_W-1:0] sum);
    return OUT_W'(sum >>> AVG_LOG2);
  endfunction

  state_t                    r_state;
  state_t                    w_state_nx;
  logic                      r_rxclk_d;
  logic                      r_demod_d;
  logic signed [DATA_W-1:0]  w_smp_p0;
  logic signed [DATA_W-1:0]  r_smp_p1;
  logic                      r_vld_p1;
  logic signed [ACC_W-1:0]   r_acc;
  logic [4:0]                r_blk_cnt;
  logic signed [OUT_W-1:0]   r_pend;
  logic                      r_pend_vld;
  logic                      r_ovf;
  logic [7:0]                r_cnt;

  logic                      w_strobe;
  logic                      w_rise;
  logic                      w_accept;
  logic                      w_enter;
  logic                      w_gate_done;
  logic signed [ACC_W-1:0]   w_smp_ext;
  logic signed [ACC_W-1:0]   w_sum;
  logic                      w_blk_done;
  logic                      w_write;

`ifdef OTR_CLAMP_EN
  // Out-of-range samples are pinned to the full-scale value on their own side.
  function automatic logic signed [DATA_W-1:0] f_clamp(input logic signed [DATA_W-1:0] smp,
                                                       input logic otr);
    if (!otr) return smp;
    return smp[DATA_W-1] ? 14'sh2000 : 14'sh1FFF;
  endfunction

  assign w_smp_p0 = f_clamp(RX, RX_OTR);
`else
  logic w_unused_otr;
  assign w_unused_otr = RX_OTR;
  assign w_smp_p0     = RX;
`endif

  assign w_strobe   = RX_CLK & ~r_rxclk_d;
  assign w_rise     = DEMOD_ON & ~r_demod_d;
  assign w_accept   = w_strobe && ENABLE && DEMOD_ON && (r_state == S_CAPTURE) &&
                      (r_cnt < CNT_MAX);
  assign w_smp_ext  = {{(ACC_W-DATA_W){r_smp_p1[DATA_W-1]}}, r_smp_p1};
  assign w_sum      = r_acc + w_smp_ext;
  assign w_blk_done = r_vld_p1 && (r_blk_cnt == BLK_LAST);

  // A pending word leaves only when storage is ready; reset/disable mask it at once.
  assign w_write    = r_pend_vld && wr.READY2WRITE && ENABLE && !RESET;
  assign wr.WRITE   = w_write;
  assign wr.DOUT    = w_write ? r_pend : '0;

  assign GATE_DONE  = w_gate_done && !RESET;
  assign OVERFLOW   = r_ovf;
  assign SAMPLE_CNT = r_cnt;

  // Edge-detect history for the sample clock and the gate window.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rxclk_d <= 1'b0;
      r_demod_d <= 1'b0;
    end else begin
      r_rxclk_d <= RX_CLK;
      r_demod_d <= DEMOD_ON;
    end
  end

  // Gate sequencer state register.
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // Gate sequencer next state; ENABLE low overrides every transition.
  always_comb begin
    w_state_nx  = r_state;
    w_gate_done = 1'b0;
    w_enter     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_nx = S_CAPTURE;
          w_enter    = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (!DEMOD_ON) w_state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        // Wait for any in-flight sample and the pending word to clear.
        if (!r_pend_vld && !r_vld_p1) w_state_nx = S_DONE;
      end
      S_DONE: begin
        w_gate_done = 1'b1;
        w_state_nx  = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
    if (!ENABLE) begin
      w_state_nx  = S_IDLE;
      w_gate_done = 1'b0;
      w_enter     = 1'b0;
    end
  end

  // Stage p0 -> p1: sample register, loaded on every strobe.
  always_ff @(posedge CLK) begin
    if (w_strobe) r_smp_p1 <= w_smp_p0;
  end

  // Stage p0 -> p1: accepted-sample flag travelling with the sample.
  always_ff @(posedge CLK) begin
    if (RESET || !ENABLE) r_vld_p1 <= 1'b0;
    else                  r_vld_p1 <= w_accept;
  end

  // Stage p1: block accumulator; a completed block restarts it at zero.
  always_ff @(posedge CLK) begin
    if (RESET || !ENABLE) begin
      r_acc     <= '0;
      r_blk_cnt <= '0;
    end else if (w_enter || (r_state == S_DONE)) begin
      r_acc     <= '0;
      r_blk_cnt <= '0;
    end else if (r_vld_p1) begin
      if (w_blk_done) begin
        r_acc     <= '0;
        r_blk_cnt <= '0;
      end else begin
        r_acc     <= w_sum;
        r_blk_cnt <= r_blk_cnt + 5'd1;
      end
    end
  end

  // Stage p1 -> p2: one-deep pending word and sticky overflow on a lost word.
  always_ff @(posedge CLK) begin
    if (RESET || !ENABLE) begin
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_blk_done && (!r_pend_vld || w_write)) begin
        r_pend     <= f_avg(w_sum);
        r_pend_vld <= 1'b1;
      end else if (w_write) begin
        r_pend_vld <= 1'b0;
      end
      if (w_blk_done && r_pend_vld && !w_write) r_ovf <= 1'b1;
    end
  end

  // Accepted-sample count; holds after the gate until the next gate starts.
  always_ff @(posedge CLK) begin
    if (RESET)         r_cnt <= '0;
    else if (w_enter)  r_cnt <= '0;
    else if (w_accept) r_cnt <= r_cnt + 8'd1;
  end

endmodule

// File: tb/tb_adc_gate_capture.sv
// Testbench for adc_gate_capture (AVG_LOG2=2, GATE_MAX=64).
// Random ADC samples are driven through gates; expected output words are
// computed from block averages of the accepted samples.
`timescale 1ns/1ps
module tb_adc_gate_capture;

  localparam int AVG_N    = 4;
  localparam int GATE_MAX = 64;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ENABLE;
  logic        RX_CLK;
  logic [13:0] RX;
  logic        RX_OTR;
  logic        DEMOD_ON;
  logic        GATE_DONE;
  logic        OVERFLOW;
  logic [7:0]  SAMPLE_CNT;

  adc_gate_capture_if wr();

  adc_gate_capture #(.AVG_LOG2(2), .GATE_MAX(GATE_MAX)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .ENABLE     (ENABLE),
    .RX_CLK     (RX_CLK),
    .RX         (RX),
    .RX_OTR     (RX_OTR),
    .DEMOD_ON   (DEMOD_ON),
    .wr         (wr),
    .GATE_DONE  (GATE_DONE),
    .OVERFLOW   (OVERFLOW),
    .SAMPLE_CNT (SAMPLE_CNT)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int gd_cnt   = 0;
  int gd_cyc   = 0;
  int wq[$];
  int wcyc[$];
  int strobe_cyc[$];
  int exp_q[$];

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Monitor: collect written words and GATE_DONE pulses mid-cycle.
  always @(negedge CLK) begin
    if (wr.WRITE === 1'b1) begin
      wq.push_back(int'($signed(wr.DOUT)));
      wcyc.push_back(cyc);
      check("write_needs_ready", int'(wr.READY2WRITE), 1);
    end
    if (GATE_DONE === 1'b1) begin
      gd_cnt++;
      gd_cyc = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic strobe(input int v, input bit otr);
    RX     = 14'(v);
    RX_OTR = otr;
    RX_CLK = 1'b1;
    strobe_cyc.push_back(cyc);
    tick(1);
    RX_CLK = 1'b0;
    tick($urandom_range(1, 3));
  endtask

  function automatic int model_val(input int v, input bit otr);
`ifdef OTR_CLAMP_EN
    if (otr) return (v < 0) ? -8192 : 8191;
`endif
    return v;
  endfunction

  // Reference: average of every complete group of AVG_N among accepted samples.
  task automatic build_exp(input int vals[$], input bit otrs[$]);
    int n;
    int sum;
    exp_q = {};
    n = (vals.size() > GATE_MAX) ? GATE_MAX : vals.size();
    for (int b = 0; b < n / AVG_N; b++) begin
      sum = 0;
      for (int k = 0; k < AVG_N; k++) sum += model_val(vals[b*AVG_N+k], otrs[b*AVG_N+k]);
      exp_q.push_back(sum >>> 2);
    end
  endtask

  task automatic wait_done(input string tag, input int g0);
    int k = 0;
    while (gd_cnt == g0 && k < 400) begin
      tick(1);
      k++;
    end
    check({tag, "_done_seen"}, int'(gd_cnt != g0), 1);
    tick(2);
  endtask

  task automatic rand_vals(input int n, output int vals[$], output bit otrs[$]);
    vals = {};
    otrs = {};
    for (int i = 0; i < n; i++) begin
      vals.push_back(int'($urandom_range(0, 16383)) - 8192);
      otrs.push_back(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
    end
  endtask

  task automatic open_gate_and_strobe(input int vals[$], input bit otrs[$]);
    wq = {};
    wcyc = {};
    strobe_cyc = {};
    build_exp(vals, otrs);
    DEMOD_ON = 1'b1;
    tick(2);
    foreach (vals[i]) strobe(vals[i], otrs[i]);
    tick(3);
  endtask

  task automatic run_gate(input string tag, input int vals[$], input bit otrs[$]);
    int g0;
    int n;
    g0 = gd_cnt;
    open_gate_and_strobe(vals, otrs);
    DEMOD_ON = 1'b0;
    wait_done(tag, g0);
    n = (vals.size() > GATE_MAX) ? GATE_MAX : vals.size();
    check({tag, "_nwrites"}, wq.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < wq.size()) check($sformatf("%s_dout%0d", tag, i), wq[i], exp_q[i]);
    check({tag, "_gate_done_once"}, gd_cnt - g0, 1);
    check({tag, "_sample_cnt"}, int'(SAMPLE_CNT), n);
    check({tag, "_overflow"}, int'(OVERFLOW), 0);
  endtask

  int  vals[$];
  bit  otrs[$];
  int  g0;

  initial begin
    RESET = 1'b1;
    ENABLE = 1'b0;
    RX_CLK = 1'b0;
    RX = '0;
    RX_OTR = 1'b0;
    DEMOD_ON = 1'b0;
    wr.READY2WRITE = 1'b0;
    tick(3);

    // Reset state
    check("rst_write", int'(wr.WRITE), 0);
    check("rst_dout", int'(wr.DOUT), 0);
    check("rst_gate_done", int'(GATE_DONE), 0);
    check("rst_overflow", int'(OVERFLOW), 0);
    check("rst_sample_cnt", int'(SAMPLE_CNT), 0);

    RESET = 1'b0;
    ENABLE = 1'b1;
    wr.READY2WRITE = 1'b1;
    tick(2);

    // Directed averaging gate, plus first-write latency
    vals = '{100, 102, 98, 100, -4, -4, -4, -4};
    otrs = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_gate("basic", vals, otrs);
    check("basic_w0_const", (wq.size() > 0) ? wq[0] : -99999, 100);
    check("basic_w1_const", (wq.size() > 1) ? wq[1] : -99999, -4);
    check("basic_latency", (wq.size() > 0) ? wcyc[0] - strobe_cyc[3] : -1, 2);

    // Random gates of assorted length
    for (int g = 0; g < 4; g++) begin
      rand_vals($urandom_range(1, 40), vals, otrs);
      run_gate($sformatf("rand%0d", g), vals, otrs);
    end

    // More strobes than GATE_MAX
    rand_vals(80, vals, otrs);
    run_gate("gatemax", vals, otrs);

    // Gate closes after a partial block
    rand_vals(6, vals, otrs);
    run_gate("partial", vals, otrs);

    // Storage stalled across two block completions
    wr.READY2WRITE = 1'b0;
    g0 = gd_cnt;
    rand_vals(8, vals, otrs);
    open_gate_and_strobe(vals, otrs);
    DEMOD_ON = 1'b0;
    tick(10);
    check("ovf_set", int'(OVERFLOW), 1);
    check("ovf_no_done_yet", gd_cnt - g0, 0);
    check("ovf_no_write_yet", wq.size(), 0);
    wr.READY2WRITE = 1'b1;
    wait_done("ovf", g0);
    check("ovf_nwrites", wq.size(), 1);
    check("ovf_word", (wq.size() > 0) ? wq[0] : -99999, exp_q[0]);
    check("ovf_done_after_write", int'((wq.size() > 0) && (gd_cyc > wcyc[0])), 1);
    check("ovf_sticky", int'(OVERFLOW), 1);
    ENABLE = 1'b0;
    tick(1);
    check("dis_ovf_clear", int'(OVERFLOW), 0);
    ENABLE = 1'b1;
    tick(2);

    // ENABLE drop mid-gate with a word pending
    wr.READY2WRITE = 1'b0;
    g0 = gd_cnt;
    rand_vals(4, vals, otrs);
    open_gate_and_strobe(vals, otrs);
    ENABLE = 1'b0;
    wr.READY2WRITE = 1'b1;
    tick(1);
    DEMOD_ON = 1'b0;
    tick(8);
    check("dis_no_write", wq.size(), 0);
    check("dis_no_done", gd_cnt - g0, 0);
    ENABLE = 1'b1;
    tick(2);

    // Reset mid-gate with a word pending
    wr.READY2WRITE = 1'b0;
    g0 = gd_cnt;
    rand_vals(8, vals, otrs);
    open_gate_and_strobe(vals, otrs);
    RESET = 1'b1;
    DEMOD_ON = 1'b0;
    wr.READY2WRITE = 1'b1;
    tick(1);
    check("mrst_write", int'(wr.WRITE), 0);
    check("mrst_dout", int'(wr.DOUT), 0);
    check("mrst_gate_done", int'(GATE_DONE), 0);
    check("mrst_overflow", int'(OVERFLOW), 0);
    check("mrst_sample_cnt", int'(SAMPLE_CNT), 0);
    RESET = 1'b0;
    tick(4);
    check("mrst_no_write", wq.size(), 0);
    check("mrst_no_done", gd_cnt - g0, 0);
    vals = '{100, 102, 98, 100, -4, -4, -4, -4};
    otrs = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_gate("after_rst", vals, otrs);

    // Out-of-range flag on a small positive sample
    vals = '{5, 5, 5, 5};
    otrs = '{1, 1, 1, 1};
    run_gate("otr", vals, otrs);
`ifdef OTR_CLAMP_EN
    check("otr_const", (wq.size() > 0) ? wq[0] : -99999, 8191);
`else
    check("otr_const", (wq.size() > 0) ? wq[0] : -99999, 5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
